// File: rtl/mantissa_shift_controller_pkg.sv
// Shared encodings for the mantissa shift controller and its remaining-count counter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mantissa_shift_controller_pkg;

    localparam int MANT_W         = 24;
    localparam int MAX_NORM_SHIFT = 23;
    localparam int CNT_W          = 5;

    // Register select encodings driven on S
    localparam logic [1:0] SEL_HOLD  = 2'b00;
    localparam logic [1:0] SEL_RIGHT = 2'b01;
    localparam logic [1:0] SEL_LEFT  = 2'b10;
    localparam logic [1:0] SEL_LOAD  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        SHIFT = 2'b10,
        DONE  = 2'b11
    } state_t;

    // Any align amount past the mantissa width empties the register, so cap it there
    function automatic logic [CNT_W-1:0] clamp_shamt(input logic [CNT_W-1:0] amt);
        return (amt > CNT_W'(MANT_W)) ? CNT_W'(MANT_W) : amt;
    endfunction

endpackage

// File: rtl/mantissa_shift_controller_down.sv
// Loadable down-counter tracking how many align shifts remain.
// Latency: load/decrement visible the cycle after the request; is_zero is combinational.
// Backpressure: none; decrement saturates at zero.
module shift_down_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         is_zero
);

    logic [W-1:0] count;

    // Load wins over decrement; decrement never wraps below zero
    always_ff @(posedge clk) begin
        if (!clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign is_zero = (count == '0);

endmodule

// File: rtl/mantissa_shift_controller.sv
// Sequences an external 24-bit shift register to align (right shift) or normalize (left shift) a mantissa.
// Latency: done pulses 3+n cycles after start (n = clamped align amount or normalize shift count).
// Backpressure: start is ignored while busy, including the done cycle.
module mantissa_shift_controller
    import mantissa_shift_controller_pkg::*;
(
    input  logic              Clk,
    input  logic              Clear,
    input  logic              start,
    input  logic              mode,
    input  logic [CNT_W-1:0]  shamt,
    input  logic [MANT_W-1:0] data_in,
    input  logic [MANT_W-1:0] A,
    output logic [1:0]        S,
    output logic [MANT_W-1:0] I,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  shift_count,
    output logic              sticky,
    output logic              zero
);

    state_t            state;
    state_t            state_nxt;
    logic              mode_q;
    logic [MANT_W-1:0] data_q;
    logic              accept;
    logic              dec;
    logic              cnt_zero;
    logic              norm_stop;

    // Only IDLE has busy low, so gating on the state is enough
    assign accept = (state == IDLE) && start;

    // Normalization stops on a set MSB, an empty register, or the shift cap
    assign norm_stop = A[MANT_W-1] || (A == '0) || (shift_count == CNT_W'(MAX_NORM_SHIFT));

    shift_down_counter #(.W(CNT_W)) u_remaining (
        .clk      (Clk),
        .clear    (Clear),
        .load     (accept),
        .load_val (clamp_shamt(shamt)),
        .dec      (dec),
        .is_zero  (cnt_zero)
    );

    // Next-state and register select decode
    always_comb begin
        state_nxt = state;
        S         = SEL_HOLD;
        dec       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = LOAD;
            end
            LOAD: begin
                S         = SEL_LOAD;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                if (!mode_q) begin
                    if (cnt_zero) begin
                        state_nxt = DONE;
                    end else begin
                        S   = SEL_RIGHT;
                        dec = 1'b1;
                    end
                end else begin
                    if (norm_stop) state_nxt = DONE;
                    else           S         = SEL_LEFT;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign I    = (S == SEL_LOAD) ? data_q : '0;
    assign done = (state == DONE);

    // State register
    always_ff @(posedge Clk) begin
        if (!Clear) state <= IDLE;
        else        state <= state_nxt;
    end

    // Captured operands and result flags; flags persist until the next accepted start
    always_ff @(posedge Clk) begin
        if (!Clear) begin
            mode_q      <= 1'b0;
            data_q      <= '0;
            busy        <= 1'b0;
            shift_count <= '0;
            sticky      <= 1'b0;
            zero        <= 1'b0;
        end else begin
            if (accept) begin
                mode_q      <= mode;
                data_q      <= data_in;
                busy        <= 1'b1;
                shift_count <= '0;
                sticky      <= 1'b0;
                zero        <= 1'b0;
            end
            if (state == DONE) busy <= 1'b0;
            if (S == SEL_RIGHT) begin
                shift_count <= shift_count + 1'b1;
                sticky      <= sticky | A[0];
            end
            if (S == SEL_LEFT) shift_count <= shift_count + 1'b1;
            if ((state == SHIFT) && mode_q && (A == '0)) zero <= 1'b1;
        end
    end

endmodule

// File: doc/mantissa_shift_controller.md
MANTISSA_SHIFT_CONTROLLER -- requirements
Module: mantissa_shift_controller

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, with ports listed in the order below.
REQ-002 Port list:
- Clk  input  1  rising-edge clock.
- Clear  input  1  synchronous active-low reset.
- start  input  1  request; sampled only when busy=0.
- mode  input  1  0=align (right shift by shamt), 1=normalize (left shift until MSB set).
- shamt  input  5  align shift amount, 0..31.
- data_in  input  24  mantissa to load.
- A  input  24  current contents of the external 24-bit bidirectional shift register.
- S  output  2  register select: 00 hold, 01 shift right (toward bit 0, 0 into bit 23), 10 shift left (0 into bit 0), 11 parallel load.
- I  output  24  parallel-load data to the register.
- busy  output  1  operation in progress.
- done  output  1  one-cycle completion pulse.
- shift_count  output  5  shifts performed in the last operation.
- sticky  output  1  align mode: OR of all 1 bits shifted out of bit 0.
- zero  output  1  normalize mode: the loaded value was all zero.

Function
REQ-003 The FSM SHALL have four states: IDLE, LOAD, SHIFT, DONE.
REQ-004 In IDLE with start=1, the block SHALL capture mode, min(shamt,24) and data_in, clear shift_count, sticky and zero, set busy=1, and go to LOAD.
REQ-005 In IDLE without start, S SHALL be 00.
REQ-006 LOAD SHALL last one cycle, with S=11 and I=captured data_in, then go to SHIFT.
REQ-007 In align SHIFT, if the remaining count is 0, the block SHALL drive S=00 and go to DONE.
REQ-008 Otherwise (align SHIFT), it SHALL drive S=01, decrement the remaining count, increment shift_count, and set sticky |= A[0].
REQ-009 In normalize SHIFT, if A[23]=1, A=0 or shift_count=23, the block SHALL drive S=00 and go to DONE.
REQ-010 In normalize SHIFT, zero SHALL be set to 1 when A=0.
REQ-011 Otherwise (normalize SHIFT), it SHALL drive S=10 and increment shift_count.
REQ-012 In DONE, the block SHALL drive done=1 and S=00, clear busy, and go to IDLE.
REQ-013 shift_count, sticky and zero SHALL hold their values until the next accepted start.
REQ-014 Latency: with start at cycle t, align with n=min(shamt,24) SHALL give done at t+3+n; normalize with k leading zeros (k≤23) SHALL give done at t+3+k.
REQ-015 A nonzero normalize with k≥23 SHALL stop after 23 shifts; a zero input SHALL give shift_count=0 and zero=1.
REQ-016 start while busy=1, including in the DONE cycle, SHALL be ignored.
REQ-017 start in the cycle after DONE SHALL be accepted.
REQ-018 shamt≥24 SHALL be clamped to 24 shifts, leaving A all zero; sticky SHALL equal the OR of all 24 loaded bits.
REQ-019 I SHALL equal the captured data_in whenever S=11 and SHALL be 0 otherwise.

Reset
REQ-020 When Clear=0 at a rising edge, the block SHALL go to IDLE with S=00, I=0, busy=0, done=0, shift_count=0, sticky=0 and zero=0, regardless of state.
REQ-021 A reset during LOAD or SHIFT SHALL abort the operation with no done pulse.
REQ-022 The external register is cleared by the same Clear signal.
REQ-023 The first start after Clear returns to 1 SHALL be accepted normally.

Structure
REQ-024 A shared package SHALL hold the S encodings (SEL_HOLD=00, SEL_RIGHT=01, SEL_LEFT=10, SEL_LOAD=11), the FSM state encoding, MANT_W=24 and MAX_NORM_SHIFT=23.
REQ-025 The remaining-count decrementer SHALL be one sub-module, shift_down_counter, 5 bits, with load, decrement and is_zero.
REQ-026 All other logic SHALL be inline; the controller SHALL NOT contain the shift register.
REQ-027 The bench SHALL pair the controller with a behavioural model of the 24-bit register.

Verification
REQ-028 Align: data_in=0xC00003, shamt=2, start at t -> S=11 at t+1, S=01 at t+2 and t+3, A=0x300000, sticky=1, shift_count=2, done at t+5.
REQ-029 Align: shamt=0 -> no S=01 cycles, done at t+3, sticky=0; shamt=31 with data_in=0x000001 -> 24 shifts, A=0, sticky=1, shift_count=24, done at t+27.
REQ-030 Normalize: data_in=0x001234 -> 11 left shifts, A=0x91A000, shift_count=11, zero=0, done at t+14.
REQ-031 Normalize: data_in=0 -> shift_count=0, zero=1, done at t+3; data_in=0x800000 -> shift_count=0, done at t+3.
REQ-032 Reset and handshake: Clear=0 during the 5th SHIFT cycle -> S=00, busy=0 and no done the next cycle; start held high throughout -> one operation per start acceptance, with start ignored while busy.
